// File: rtl/ztj_pkg.sv
// Shared definitions for the tick generator: FSM state encoding and a
// counter-width helper used by the top and the key debouncer.
package ztj_pkg;

    // One-hot state encoding; any other value is treated as illegal.
    typedef enum logic [2:0] {
        TG_IDLE  = 3'b001,
        TG_RUN   = 3'b010,
        TG_PAUSE = 3'b100
    } tg_state_e;

    // Width needed to hold 0..n-1, never less than one bit.
    function automatic int tg_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button front end: two-flop synchroniser, stability counter and
// falling-edge detect. Produces a one-cycle pulse per accepted press.
module key_debounce
    import ztj_pkg::*;
#(
    parameter int DEB_CNT = 1_000_000
)(
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_press
);

    localparam int               DEB_W    = tg_width(DEB_CNT);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CNT - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             key_stable_q;
    logic             key_stable_d;
    logic             key_stable_dly_q;
    logic [DEB_W-1:0] cnt_q;
    logic [DEB_W-1:0] cnt_d;

    // Accept a new key level only after it has differed from the stable
    // level for DEB_CNT consecutive cycles; any bounce back restarts the count.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise paths that skip an assignment infer a latch.
        key_stable_d = key_stable_q;
        cnt_d        = '0;
        if (sync2_q != key_stable_q) begin
            if (cnt_q == DEB_LAST) begin
                key_stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + DEB_W'(1);
            end
        end
    end

    // Synchroniser, debounce state and edge-detect history; idle level is released (1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q          <= 1'b1;
            sync2_q          <= 1'b1;
            key_stable_q     <= 1'b1;
            key_stable_dly_q <= 1'b1;
            cnt_q            <= '0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge values, so the sync chain shifts by exactly one stage.
            sync1_q          <= key_in;
            sync2_q          <= sync1_q;
            key_stable_q     <= key_stable_d;
            key_stable_dly_q <= key_stable_q;
            cnt_q            <= cnt_d;
        end
    end

    // Press is the accepted high-to-low transition; release yields nothing.
    assign key_press = key_stable_dly_q & ~key_stable_q;

endmodule

// File: rtl/ztj_tick_gen.sv
// Enable generator for the light sequencer: a one-cycle en pulse every DIV
// clocks while running; the push-button toggles start/pause/resume.
module ztj_tick_gen
    import ztj_pkg::*;
#(
    parameter int DIV     = 50_000_000,
    parameter int DEB_CNT = 1_000_000
)(
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    input  logic clr,
    output logic en,
    output logic running,
    output logic paused
);

    localparam int               DIV_W    = tg_width(DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    logic             key_press;
    tg_state_e        state_q;
    tg_state_e        state_d;
    logic [DIV_W-1:0] presc_q;
    logic [DIV_W-1:0] presc_d;
    logic             en_q;
    logic             en_d;

    key_debounce #(
        .DEB_CNT (DEB_CNT)
    ) u_key_debounce (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_in    (key_in),
        .key_press (key_press)
    );

    // Next state, prescaler and tick; clr wins over a simultaneous press and
    // suppresses a tick that would otherwise fall on the same cycle.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        en_d    = 1'b0;
        if (clr) begin
            state_d = TG_IDLE;
            presc_d = '0;
        end else begin
            case (state_q)
                TG_IDLE: begin
                    presc_d = '0;
                    if (key_press) state_d = TG_RUN;
                end
                TG_RUN: begin
                    // A press on the wrap cycle still issues its tick, then pauses at 0.
                    if (presc_q == DIV_LAST) begin
                        en_d    = 1'b1;
                        presc_d = '0;
                    end else begin
                        presc_d = presc_q + DIV_W'(1);
                    end
                    if (key_press) state_d = TG_PAUSE;
                end
                TG_PAUSE: begin
                    // Prescaler holds so a resume completes the interrupted period.
                    if (key_press) state_d = TG_RUN;
                end
                default: begin
                    state_d = TG_IDLE;
                    presc_d = '0;
                end
            endcase
        end
    end

    // State, prescaler and registered tick output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TG_IDLE;
            presc_q <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            en_q    <= en_d;
        end
    end

    assign en      = en_q;
    assign running = (state_q == TG_RUN);
    assign paused  = (state_q == TG_PAUSE);

endmodule
